// File: rtl/aes_sbox_array.sv
// Time-multiplexed AES SubBytes/InvSubBytes engine: a DATA_BYTES state word is
// substituted LANES bytes per clock between two valid/ready handshakes.
module aes_sbox_array #(
    parameter int unsigned DATA_BYTES = 16,
    parameter int unsigned LANES      = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [8*DATA_BYTES-1:0] in_data,
    input  logic                    in_inv,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [8*DATA_BYTES-1:0] out_data,
    output logic                    out_inv
);

    localparam int unsigned W  = 8 * DATA_BYTES;
    localparam int unsigned N  = DATA_BYTES / LANES;
    localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW = (W > 2) ? $clog2(W) : 1;

    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16) ||
        (DATA_BYTES % LANES != 0)) begin : g_param_check
        $error("aes_sbox_array: LANES must be 1/2/4/8/16 and divide DATA_BYTES");
    end

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
        8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
        8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
        8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
        8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
        8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
        8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
        8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
        8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
        8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
        8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
        8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
        8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
        8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
        8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
        8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
        8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    hold_q, hold_d;
    logic            inv_q, inv_d;
    logic [BW-1:0]   beat_q, beat_d;

    logic [IW-1:0]   lane_base [LANES];
    logic [7:0]      lane_in   [LANES];
    logic [7:0]      lane_out  [LANES];

    // Each lane owns one byte slot of the current beat and carries both tables.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [7:0] fwd_b;
        logic [7:0] inv_b;
        assign lane_base[k] = IW'(8 * (int'(beat_q) * int'(LANES) + k));
        assign lane_in[k]   = hold_q[lane_base[k] +: 8];
        assign fwd_b        = SBOX[lane_in[k]];
        assign inv_b        = INV_SBOX[lane_in[k]];
        assign lane_out[k]  = inv_q ? inv_b : fwd_b;
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        inv_d   = inv_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    hold_d  = in_data;
                    inv_d   = in_inv;
                    beat_d  = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                for (int k = 0; k < int'(LANES); k++) begin
                    hold_d[lane_base[k] +: 8] = lane_out[k];
                end
                if (beat_q == BW'(N - 1)) begin
                    state_d = StDone;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            StDone: begin
                // Output handshake and the next accept may share one edge.
                if (out_ready) begin
                    if (in_valid) begin
                        hold_d  = in_data;
                        inv_d   = in_inv;
                        beat_d  = '0;
                        state_d = StRun;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            hold_q  <= '0;
            inv_q   <= 1'b0;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            inv_q   <= inv_d;
            beat_q  <= beat_d;
        end
    end

    assign in_ready  = rst_n & ((state_q == StIdle) | ((state_q == StDone) & out_ready));
    assign out_valid = (state_q == StDone);
    assign out_data  = hold_q;
    assign out_inv   = inv_q;

endmodule

// File: tb/tb_aes_sbox_array.sv
// Randomised bench for aes_sbox_array against an S-box model derived from GF(2^8)
// inversion and the affine map; a LANES sweep runs in parallel instances.
module tb_aes_sbox_array;

    localparam logic [127:0] SEQ   = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] FWD_S = 128'h76abd7fe2b670130c56f6bf27b777c63;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
    logic [127:0] in_data, out_data;

    logic         sw_valid, sw_inv, sw_out_ready;
    logic [127:0] sw_data;
    logic         sw_in_ready  [4];
    logic         sw_out_valid [4];
    logic         sw_out_inv   [4];
    logic [127:0] sw_out_data  [4];

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] fwd_t [256];
    logic [7:0] inv_t [256];

    always #5 clk = ~clk;

    aes_sbox_array #(.DATA_BYTES(16), .LANES(4)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_inv(out_inv)
    );

    for (genvar g = 0; g < 4; g++) begin : g_sweep
        aes_sbox_array #(
            .DATA_BYTES(16),
            .LANES(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 8 : 16)
        ) u_sw (
            .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(sw_in_ready[g]),
            .in_data(sw_data), .in_inv(sw_inv), .out_valid(sw_out_valid[g]),
            .out_ready(sw_out_ready), .out_data(sw_out_data[g]), .out_inv(sw_out_inv[g])
        );
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic init_model();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] b = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) b = 8'(y);
            fwd_t[x] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
            inv_t[fwd_t[x]] = 8'(x);
        end
    endtask

    function automatic logic [127:0] model(input logic [127:0] d, input logic inv);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = inv ? inv_t[d[8*i +: 8]] : fwd_t[d[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Presents a word in IDLE for exactly one edge, then scrambles the ignored inputs.
    task automatic accept_word(input logic [127:0] d, input logic inv);
        in_valid = 1'b1; in_data = d; in_inv = inv;
        @(posedge clk); #1;
        in_valid = 1'b0; in_data = rand128(); in_inv = ~inv;
    endtask

    task automatic wait_valid(input int budget, output int edges);
        edges = -1;
        for (int e = 1; e <= budget; e++) begin
            @(posedge clk); #1;
            if (out_valid) begin edges = e; return; end
        end
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
        sw_valid = 1'b0; sw_data = '0; sw_inv = 1'b0; sw_out_ready = 1'b1;
        #12;
        vectors++;
        if ({in_ready, out_valid, out_inv} !== 3'b000 || out_data !== '0) begin
            miscompares++;
            $display("FAIL reset_state: rdy/vld/inv=%b data=%h, required 000 and 0",
                     {in_ready, out_valid, out_inv}, out_data);
        end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_forward();
        int lat;
        accept_word(SEQ, 1'b0);
        wait_valid(20, lat);
        vectors++;
        if (lat != 4 || out_data !== FWD_S || out_inv !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL forward: lat=%0d data=%h inv=%b rdy=%b, required 4 %h 0 0",
                     lat, out_data, out_inv, in_ready, FWD_S);
        end
        release_out();
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL forward_drain: out_valid=%b in_ready=%b, required 0 1",
                     out_valid, in_ready);
        end
    endtask

    task automatic test_inverse();
        int lat;
        accept_word(FWD_S, 1'b1);
        wait_valid(20, lat);
        vectors++;
        if (lat != 4 || out_data !== SEQ || out_inv !== 1'b1) begin
            miscompares++;
            $display("FAIL inverse: lat=%0d data=%h inv=%b, required 4 %h 1",
                     lat, out_data, out_inv, SEQ);
        end
        release_out();
        accept_word({16{8'h53}}, 1'b0);
        wait_valid(20, lat);
        vectors++;
        if (lat != 4 || out_data !== {16{8'hed}}) begin
            miscompares++;
            $display("FAIL fwd_53: lat=%0d data=%h, required 4 %h", lat, out_data, {16{8'hed}});
        end
        release_out();
    endtask

    task automatic test_backpressure();
        int lat;
        logic [127:0] d = rand128();
        logic inv = 1'($urandom);
        accept_word(d, inv);
        wait_valid(20, lat);
        for (int c = 0; c < 5; c++) begin
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== model(d, inv) ||
                out_inv !== inv) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: v=%b r=%b data=%h inv=%b, required 1 0 %h %b",
                         c, out_valid, in_ready, out_data, out_inv, model(d, inv), inv);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1; in_valid = 1'b1; in_data = '0; in_inv = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL handoff_ready: in_ready=%b, required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0; in_data = rand128();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL handoff_edge: out_valid=%b, required 0", out_valid);
        end
        wait_valid(20, lat);
        vectors++;
        if (lat != 4 || out_data !== {16{8'h63}} || out_inv !== 1'b0) begin
            miscompares++;
            $display("FAIL handoff_word: lat=%0d data=%h inv=%b, required 4 %h 0",
                     lat, out_data, out_inv, {16{8'h63}});
        end
        release_out();
    endtask

    task automatic test_reset_mid_run();
        int lat;
        logic [127:0] d;
        logic inv;
        accept_word(rand128(), 1'b1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (out_valid !== 1'b0 || out_data !== '0 || out_inv !== 1'b0 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_reset: v=%b data=%h inv=%b r=%b, required 0 0 0 0",
                     out_valid, out_data, out_inv, in_ready);
        end
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL midrun_release: in_ready=%b out_valid=%b, required 1 0",
                     in_ready, out_valid);
        end
        wait_valid(6, lat);
        vectors++;
        if (lat != -1) begin
            miscompares++;
            $display("FAIL midrun_ghost: out_valid after %0d edges, required none", lat);
        end
        d = rand128(); inv = 1'($urandom);
        accept_word(d, inv);
        wait_valid(20, lat);
        vectors++;
        if (lat != 4 || out_data !== model(d, inv) || out_inv !== inv) begin
            miscompares++;
            $display("FAIL midrun_next: lat=%0d data=%h, required 4 %h",
                     lat, out_data, model(d, inv));
        end
        release_out();
    endtask

    task automatic test_mode_isolation();
        for (int w = 0; w < 4; w++) begin
            int lat = -1;
            logic [127:0] d = rand128();
            logic inv = 1'(w);
            accept_word(d, inv);
            for (int e = 1; e <= 20; e++) begin
                in_inv = ~in_inv; in_data = rand128();
                @(posedge clk); #1;
                if (out_valid) begin lat = e; break; end
            end
            vectors++;
            if (lat != 4 || out_data !== model(d, inv) || out_inv !== inv) begin
                miscompares++;
                $display("FAIL mode_iso[%0d]: lat=%0d data=%h inv=%b, required 4 %h %b",
                         w, lat, out_data, out_inv, model(d, inv), inv);
            end
            release_out();
        end
    endtask

    task automatic test_random();
        for (int w = 0; w < 16; w++) begin
            int lat;
            int hold_cycles = $urandom_range(0, 3);
            logic [127:0] d = rand128();
            logic inv = 1'($urandom);
            accept_word(d, inv);
            wait_valid(20, lat);
            repeat (hold_cycles) begin @(posedge clk); #1; end
            vectors++;
            if (lat != 4 || out_valid !== 1'b1 || out_data !== model(d, inv) ||
                out_inv !== inv) begin
                miscompares++;
                $display("FAIL random[%0d]: lat=%0d v=%b data=%h inv=%b, required 4 1 %h %b",
                         w, lat, out_valid, out_data, out_inv, model(d, inv), inv);
            end
            release_out();
        end
    endtask

    task automatic test_back_to_back();
        logic [128:0] q[$];
        logic [128:0] exp;
        int last = -1;
        logic acc;
        out_ready = 1'b1; in_valid = 1'b1; in_data = rand128(); in_inv = 1'($urandom);
        #1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            acc = in_ready;
            if (acc) q.push_back({in_inv, in_data});
            @(posedge clk); #1;
            if (acc) begin in_data = rand128(); in_inv = 1'($urandom); end
            if (out_valid) begin
                exp = (q.size() > 0) ? q.pop_front() : '0;
                vectors++;
                if (out_data !== model(exp[127:0], exp[128]) || out_inv !== exp[128] ||
                    (last >= 0 && cyc - last != 5)) begin
                    miscompares++;
                    $display("FAIL b2b@%0d: data=%h inv=%b gap=%0d, required %h %b 5",
                             cyc, out_data, out_inv, cyc - last,
                             model(exp[127:0], exp[128]), exp[128]);
                end
                last = cyc;
            end
        end
        in_valid = 1'b0;
        for (int e = 0; e < 10; e++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                exp = (q.size() > 0) ? q.pop_front() : '0;
                vectors++;
                if (out_data !== model(exp[127:0], exp[128])) begin
                    miscompares++;
                    $display("FAIL b2b_drain: data=%h, required %h",
                             out_data, model(exp[127:0], exp[128]));
                end
            end
        end
        out_ready = 1'b0;
        vectors++;
        if (q.size() != 0 || last < 0) begin
            miscompares++;
            $display("FAIL b2b_count: %0d words undelivered, last=%0d, required 0", q.size(), last);
        end
    endtask

    task automatic test_sweep();
        int lat [4] = '{-1, -1, -1, -1};
        int want [4] = '{16, 8, 2, 1};
        logic [127:0] got [4];
        sw_data = SEQ; sw_valid = 1'b1;
        @(posedge clk); #1;
        sw_valid = 1'b0; sw_data = rand128();
        for (int e = 1; e <= 24; e++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++)
                if (sw_out_valid[i] && lat[i] < 0) begin lat[i] = e; got[i] = sw_out_data[i]; end
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (lat[i] != want[i] || got[i] !== FWD_S) begin
                miscompares++;
                $display("FAIL sweep[%0d]: lat=%0d data=%h, required %0d %h",
                         i, lat[i], got[i], want[i], FWD_S);
            end
        end
    endtask

    initial begin
        init_model();
        test_reset();
        test_forward();
        test_inverse();
        test_backpressure();
        test_reset_mid_run();
        test_mode_isolation();
        test_random();
        test_back_to_back();
        test_sweep();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/aes_sbox_array.md
# aes_sbox_array

Parametrised, time-multiplexed AES byte-substitution engine for both encryption and decryption datapaths. It accepts a DATA_BYTES-wide state word over a valid/ready handshake and applies the forward or inverse S-box to every byte, LANES bytes per clock. It returns the substituted word over a second valid/ready handshake. It sits between AddRoundKey and ShiftRows (or their inverses) in the round cores, so that one block serves both directions with a selectable area/latency trade-off.

## Interface
- DATA_BYTES, 16: bytes per state word; byte i occupies bits [8i+7:8i].
- LANES, 4: S-box lookups per cycle. Must be one of 1, 2, 4, 8 or 16, and must divide DATA_BYTES; an elaboration-time check fails otherwise.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  8*DATA_BYTES  state word to substitute.
- in_inv  in  1  0 = forward S-box (encrypt), 1 = inverse S-box (decrypt); sampled only at accept.
- out_valid  out  1  substituted word available.
- out_ready  in  1  consumer takes the word this cycle.
- out_data  out  8*DATA_BYTES  substituted word; meaningful only while out_valid=1.
- out_inv  out  1  mode used for the word on out_data.

## Operation
- Let N = DATA_BYTES/LANES beats. The holding register is hold[8*DATA_BYTES-1:0], the mode register is inv_q, and the beat counter is beat, ceil(log2 N) bits wide with a minimum of 1.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid: hold<=in_data, inv_q<=in_inv, beat<=0, go to RUN.
  - RUN: in_ready=0, out_valid=0. Each cycle, lane k (k=0..LANES-1) replaces byte beat*LANES+k of hold with SBOX(byte) if inv_q=0, or INV_SBOX(byte) if inv_q=1. Lookups are combinational from the 256-entry FIPS-197 tables; both tables exist per lane. If beat=N-1, go to DONE; otherwise beat<=beat+1.
  - DONE: out_valid=1, and out_data/out_inv hold stable.
    - out_ready=0: stay in DONE.
    - out_ready=1 and in_valid=0: go to IDLE.
    - out_ready=1 and in_valid=1: output handshake and new accept occur on the same edge. Load hold/inv_q from the inputs, set beat<=0, go to RUN.
- in_ready = (state==IDLE) | (state==DONE & out_ready), which is combinational from out_ready. There is no combinational path from in_valid to in_ready.
- out_data = hold; out_inv = inv_q.
- in_inv and in_data are ignored outside accept cycles.
- Bytes not yet processed in RUN keep their input value. Each byte is substituted exactly once per word.

## Timing
- Reset (rst_n low, asynchronous): state=IDLE, hold=0, inv_q=0, beat=0, so out_valid=0, out_data=0, out_inv=0. in_ready is forced to 0 while rst_n=0 and returns to 1 in the first cycle after deassertion.
- Reset during RUN or DONE discards the word in flight; no out_valid pulse is produced for it.
- Latency: if the accept happens at edge t, out_valid is 1 after edge t+N. With LANES=DATA_BYTES (N=1), out_valid is 1 after edge t+1.
- Throughput with out_ready tied high and a continuous input stream: one word per N+1 cycles (RUN for N cycles, DONE for 1 cycle overlapped with the next accept).
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_inv are bit-stable and in_ready=0.
- beat never exceeds N-1 and does not wrap within a word.
- For N=1 the counter is unused, but RUN still lasts exactly one cycle.

## Test plan
- Forward, defaults (16 bytes, LANES=4): in_data bytes 0..15 = 00,01,…,0F, in_inv=0, accept at edge 0. Required: out_valid high after edge 4; out_data bytes = 63,7C,77,7B,F2,6B,6F,C5,30,01,67,2B,FE,D7,AB,76; out_inv=0.
- Inverse round-trip: feed the output word above with in_inv=1. Required: out_data bytes = 00..0F and out_inv=1. Also feed all bytes 53 with in_inv=0 and require all bytes ED.
- Backpressure plus back-to-back: hold out_ready=0 for 5 cycles in DONE. Required: out_data stable and in_ready=0 throughout. Then assert out_ready with in_valid=1 (all bytes 00, inv=0). Required: same-edge handoff, and the next out_valid arrives 4 edges later with all bytes 63.
- Reset mid-RUN: deassert rst_n asynchronously during the 2nd beat. Required: out_valid=0 and out_data=0 immediately; in_ready=1 after release; the next word processes correctly.
- Parameter sweep LANES=1, 2, 8, 16 with the 00..0F vector. Required: latency 16, 8, 2, 1 respectively, with an identical out_data result.
- Mode isolation: toggle in_inv every cycle during RUN. Required: the result matches the mode captured at accept.
